fp_mult_r5: RTL and testbench

- Parameterized IEEE-754 binary floating-point multiplier: z = round(a × b) plus an 8-bit exception status word.
- Full subnormal support; RISC-V rounding-mode encoding.
- Single output register stage. Used as the FPU multiply unit; bit-exact against a standard IEEE-compliant multiplier model.

---
 rtl/fp_mult_pkg.sv | 42 ++++
 rtl/fp_mult_unpack.sv | 41 ++++
 rtl/fp_mult_r5.sv | 170 +++++++++++++++++
 tb/tb_fp_mult_r5.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: rounding modes, status bit positions and rounding helpers
// shared by the fp_mult_r5 multiplier.
package fp_mult_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   localparam int ST_ZERO    = 0;
   localparam int ST_INF     = 1;
   localparam int ST_INVALID = 2;
   localparam int ST_TINY    = 3;
   localparam int ST_HUGE    = 4;
   localparam int ST_INEXACT = 5;

   // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
   function automatic logic [63:0] qnan(input int ew, input int sw);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < ew; i++) r[sw+i] = 1'b1;
      r[sw-1] = 1'b1;
      return r;
   endfunction

   function automatic logic round_up(input rm_e rm, input logic sign, input logic lsb,
                                     input logic g, input logic s);
      return (rm == RM_RTZ) ? 1'b0 :
             (rm == RM_RDN) ? sign & (g | s) :
             (rm == RM_RUP) ? ~sign & (g | s) :
             (rm == RM_RMM) ? g :
                              g & (s | lsb);
   endfunction

   function automatic logic ovf_to_inf(input rm_e rm, input logic sign);
      return (rm == RM_RNE) | (rm == RM_RMM) | ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);
   endfunction

endpackage

// File: rtl/fp_mult_unpack.sv
// fp_mult_unpack: widens the exponent, normalizes subnormals so every finite
// nonzero operand carries a hidden 1, and classifies zero/inf/NaN.
module fp_mult_unpack
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int SIG_W = 10
) (
   input  logic [EXP_W+SIG_W:0] i_op,
   output logic                 o_sign,
   output logic signed [EXP_W:0] o_exp,
   output logic [SIG_W:0]       o_sig,
   output logic                 o_is_zero,
   output logic                 o_is_inf,
   output logic                 o_is_nan
);
   localparam int LZW = $clog2(SIG_W + 1);

   logic [EXP_W-1:0] w_e;
   logic [SIG_W-1:0] w_f;
   logic [LZW-1:0]   w_lz;
   logic             w_sub;

   assign o_sign = i_op[EXP_W+SIG_W];
   assign w_e    = i_op[EXP_W+SIG_W-1:SIG_W];
   assign w_f    = i_op[SIG_W-1:0];
   assign w_sub  = (w_e == '0);

   always_comb begin
      w_lz = '0;
      for (int i = 0; i < SIG_W; i++) if (w_f[i]) w_lz = LZW'(SIG_W - 1 - i);
   end

   // A subnormal with lz leading zeros becomes 1.f at biased exponent -lz.
   assign o_sig     = w_sub ? ({1'b0, w_f} << (w_lz + 1'b1)) : {1'b1, w_f};
   assign o_exp     = w_sub ? -$signed((EXP_W+1)'(w_lz)) : $signed({1'b0, w_e});
   assign o_is_zero = w_sub & (w_f == '0);
   assign o_is_inf  = (&w_e) & (w_f == '0);
   assign o_is_nan  = (&w_e) & (|w_f);

endmodule

// File: rtl/fp_mult_r5.sv
// fp_mult_r5: IEEE-754 multiplier with subnormals, RISC-V rounding modes and one output register.
// Defining FP_MULT_IN_REG_EN adds an input register stage (latency 2).
module fp_mult_r5
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int SIG_W = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [EXP_W+SIG_W:0] a,
   input  logic [EXP_W+SIG_W:0] b,
   input  logic [2:0]           rnd,
   output logic                 out_valid,
   output logic [EXP_W+SIG_W:0] z,
   output logic [7:0]           status
);
   localparam int W  = EXP_W + SIG_W + 1;
   localparam int S  = SIG_W;
   localparam int PW = 2 * S + 2;
   localparam int XW = EXP_W + 3;
   localparam logic signed [XW-1:0] ONE_X  = XW'(1);
   localparam logic signed [XW-1:0] PW_X   = XW'(PW);
   localparam logic signed [XW-1:0] BIAS_X = XW'(2**(EXP_W-1) - 1);
   localparam logic signed [XW-1:0] EMAX_X = XW'(2**EXP_W - 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'(2**EXP_W - 2);
   localparam logic [63:0] QNAN = qnan(EXP_W, SIG_W);

   logic [W-1:0] w_a, w_b;
   logic [2:0]   w_rnd;
   logic         w_vld;

`ifdef FP_MULT_IN_REG_EN
   logic [W-1:0] r_a, r_b;
   logic [2:0]   r_rnd;
   logic         r_vld;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_rnd <= '0;
         r_vld <= 1'b0;
      end else begin
         r_a   <= a;
         r_b   <= b;
         r_rnd <= rnd;
         r_vld <= in_valid;
      end
   end

   assign w_a   = r_a;
   assign w_b   = r_b;
   assign w_rnd = r_rnd;
   assign w_vld = r_vld;
`else
   assign w_a   = a;
   assign w_b   = b;
   assign w_rnd = rnd;
   assign w_vld = in_valid;
`endif

   logic                 w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic signed [EXP_W:0] w_ea, w_eb;
   logic [S:0]           w_ma, w_mb;

   fp_mult_unpack #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_unpack_a (
      .i_op(w_a), .o_sign(w_sa), .o_exp(w_ea), .o_sig(w_ma),
      .o_is_zero(w_za), .o_is_inf(w_ia), .o_is_nan(w_na)
   );

   fp_mult_unpack #(.EXP_W(EXP_W), .SIG_W(SIG_W)) u_unpack_b (
      .i_op(w_b), .o_sign(w_sb), .o_exp(w_eb), .o_sig(w_mb),
      .o_is_zero(w_zb), .o_is_inf(w_ib), .o_is_nan(w_nb)
   );

   rm_e                   w_rm;
   logic                  w_sign, w_den, w_g, w_st, w_gn, w_sn, w_cn, w_ovf, w_tiny, w_inx, w_hid, w_nan;
   logic [PW-1:0]         w_prod, w_pn, w_q;
   logic signed [XW-1:0]  w_exp, w_shr, w_ed, w_ef;
   logic [XW-1:0]         w_sh;
   logic [2*PW-1:0]       w_ext;
   logic [S+1:0]          w_r;
   logic [EXP_W-1:0]      w_ez;
   logic [S-1:0]          w_fz;
   logic [W-1:0]          w_fin, w_zn;
   logic [7:0]            w_stn;

   assign w_rm   = (w_rnd > 3'd4) ? RM_RNE : rm_e'(w_rnd);
   assign w_sign = w_sa ^ w_sb;
   assign w_prod = PW'(w_ma) * PW'(w_mb);
   assign w_exp  = XW'(w_ea) + XW'(w_eb) - BIAS_X + $signed({{(XW-1){1'b0}}, w_prod[PW-1]});
   assign w_pn   = w_prod[PW-1] ? w_prod : (w_prod << 1);

   // Below the normal range, shift right into subnormal position so rounding happens once.
   assign w_den = w_exp < ONE_X;
   assign w_shr = ONE_X - w_exp;
   assign w_sh  = !w_den ? '0 : ((w_shr > PW_X) ? PW_X : w_shr);
   assign w_ext = {w_pn, {PW{1'b0}}} >> w_sh;
   assign w_q   = w_ext[2*PW-1:PW];
   assign w_g   = w_q[S];
   assign w_st  = (|w_q[S-1:0]) | (|w_ext[PW-1:0]);
   assign w_r   = {1'b0, w_q[PW-1:S+1]} + {{(S+1){1'b0}}, round_up(w_rm, w_sign, w_q[S+1], w_g, w_st)};
   assign w_ed  = w_den ? ONE_X : w_exp;
   assign w_ef  = w_ed + $signed({{(XW-1){1'b0}}, w_r[S+1]});
   assign w_ovf = w_ef >= EMAX_X;
   assign w_hid = w_r[S+1] | w_r[S];
   assign w_ez  = w_hid ? w_ef[EXP_W-1:0] : '0;
   assign w_fz  = w_r[S+1] ? '0 : w_r[S-1:0];
   assign w_inx = w_g | w_st | w_ovf;

   // Tininess is judged after rounding at full precision with an unbounded exponent.
   assign w_gn   = w_pn[S];
   assign w_sn   = |w_pn[S-1:0];
   assign w_cn   = (&w_pn[PW-1:S+1]) & round_up(w_rm, w_sign, w_pn[S+1], w_gn, w_sn);
   assign w_tiny = (w_exp + $signed({{(XW-1){1'b0}}, w_cn})) < ONE_X;

   assign w_fin = !w_ovf ? {w_sign, w_ez, w_fz} :
                  ovf_to_inf(w_rm, w_sign) ? {w_sign, EXP_ONES, {S{1'b0}}} :
                                             {w_sign, EXP_MAXF, {S{1'b1}}};
   assign w_nan = w_na | w_nb | (w_za & w_ib) | (w_ia & w_zb);

   always_comb begin
      w_zn  = w_fin;
      w_stn = '0;
      if (w_nan) begin
         w_zn              = QNAN[W-1:0];
         w_stn[ST_INVALID] = 1'b1;
      end else if (w_ia | w_ib) begin
         w_zn          = {w_sign, EXP_ONES, {S{1'b0}}};
         w_stn[ST_INF] = 1'b1;
      end else if (w_za | w_zb) begin
         w_zn           = {w_sign, {(W-1){1'b0}}};
         w_stn[ST_ZERO] = 1'b1;
      end else if (w_ovf) begin
         w_stn[ST_HUGE]    = 1'b1;
         w_stn[ST_INEXACT] = 1'b1;
         w_stn[ST_INF]     = ovf_to_inf(w_rm, w_sign);
      end else begin
         w_stn[ST_ZERO]    = ~|w_fin[W-2:0];
         w_stn[ST_TINY]    = w_tiny;
         w_stn[ST_INEXACT] = w_inx;
      end
   end

   logic         r_valid;
   logic [W-1:0] r_z;
   logic [7:0]   r_status;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid  <= 1'b0;
         r_z      <= '0;
         r_status <= '0;
      end else begin
         r_valid <= w_vld;
         if (w_vld) begin
            r_z      <= w_zn;
            r_status <= w_stn;
         end
      end
   end

   assign out_valid = r_valid;
   assign z         = r_z;
   assign status    = r_status;

endmodule

// File: tb/tb_fp_mult_r5.sv
// tb_fp_mult_r5: directed and randomized checks of fp_mult_r5 against an
// exact-integer rounding model of the multiplier.
module tb_fp_mult_r5;
   localparam int EW   = 5;
   localparam int SW   = 10;
   localparam int W    = EW + SW + 1;
   localparam int BIAS = 2**(EW-1) - 1;
   localparam int EMIN = 1 - BIAS;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   rnd = '0;
   logic         out_valid;
   logic [W-1:0] z;
   logic [7:0]   status;
   int           n_tests = 0;
   int           n_fail = 0;

   fp_mult_r5 #(.EXP_W(EW), .SIG_W(SW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .rnd(rnd),
      .out_valid(out_valid), .z(z), .status(status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Round p*2^x to a multiple of 2^qe.
   function automatic longint rnd_to(input longint p, input int x, input int qe, input int rm,
                                     input bit sg, output bit inx);
      longint q, rem, half;
      int     sh;
      if (qe <= x) begin
         inx = 1'b0;
         return p <<< (x - qe);
      end
      sh   = (qe - x > 60) ? 60 : qe - x;
      q    = p >>> sh;
      rem  = p - (q <<< sh);
      half = longint'(1) <<< (sh - 1);
      inx  = rem != 0;
      case (rm)
         1: ;
         2: if (sg && inx) q++;
         3: if (!sg && inx) q++;
         4: if (rem >= half) q++;
         default: if (rem > half || (rem == half && q[0])) q++;
      endcase
      return q;
   endfunction

   function automatic logic [W+7:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input int rm_in);
      int           rm, ex, ey, xa, xb, e, qe, ef, msb;
      longint       ma, mb, p, q, qu;
      bit           sg, inx, inxu, tiny, toinf;
      logic [W-1:0] r;
      rm = (rm_in > 4) ? 0 : rm_in;
      sg = x[W-1] ^ y[W-1];
      ex = int'(x[W-2:SW]);
      ey = int'(y[W-2:SW]);
      ma = longint'(x[SW-1:0]);
      mb = longint'(y[SW-1:0]);
      if ((ex == 2**EW-1 && ma != 0) || (ey == 2**EW-1 && mb != 0) ||
          (ex == 0 && ma == 0 && ey == 2**EW-1) || (ey == 0 && mb == 0 && ex == 2**EW-1)) begin
         r = '0;
         r[W-2:SW] = '1;
         r[SW-1] = 1'b1;
         return {r, 8'h04};
      end
      if (ex == 2**EW-1 || ey == 2**EW-1) return {sg, {EW{1'b1}}, {SW{1'b0}}, 8'h02};
      if ((ex == 0 && ma == 0) || (ey == 0 && mb == 0)) return {sg, {(W-1){1'b0}}, 8'h01};
      xa = (ex == 0) ? EMIN - SW : ex - BIAS - SW;
      xb = (ey == 0) ? EMIN - SW : ey - BIAS - SW;
      if (ex != 0) ma += longint'(1) <<< SW;
      if (ey != 0) mb += longint'(1) <<< SW;
      p = ma * mb;
      msb = 0;
      for (int i = 0; i < 62; i++) if (p[i]) msb = i;
      e  = msb + xa + xb;
      qe = ((e > EMIN) ? e : EMIN) - SW;
      q  = rnd_to(p, xa + xb, qe, rm, sg, inx);
      if (q >= (longint'(1) <<< (SW+1))) begin
         q = q >>> 1;
         qe++;
      end
      ef   = (q >= (longint'(1) <<< SW)) ? qe + SW + BIAS : 0;
      qu   = rnd_to(p, xa + xb, e - SW, rm, sg, inxu);
      tiny = (e + ((qu >= (longint'(1) <<< (SW+1))) ? 1 : 0)) < EMIN;
      if (ef >= 2**EW-1) begin
         toinf = rm == 0 || rm == 4 || (rm == 3 && !sg) || (rm == 2 && sg);
         r = toinf ? {sg, {EW{1'b1}}, {SW{1'b0}}} : {sg, EW'(2**EW-2), {SW{1'b1}}};
         return {r, toinf ? 8'h32 : 8'h30};
      end
      r = {sg, EW'(ef), SW'(q)};
      return {r, 2'b00, inx, 1'b0, tiny, 2'b00, q == 0};
   endfunction

   function automatic logic [W-1:0] rand_op();
      int            k;
      logic          s;
      logic [EW-1:0] e;
      logic [SW-1:0] f;
      k = $urandom_range(0, 9);
      s = 1'($urandom_range(0, 1));
      e = EW'($urandom);
      f = SW'($urandom);
      case (k)
         0: begin e = '0; f = '0; end
         1: begin e = '1; f = '0; end
         2: begin e = '1; f[0] = 1'b1; end
         3: e = '0;
         4: e = EW'(2**EW - 2 - $urandom_range(0, 3));
         5: e = EW'($urandom_range(1, 6));
         default: ;
      endcase
      return {s, e, f};
   endfunction

   task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input int rm,
                      input logic [W-1:0] ez, input logic [7:0] est);
      a = x;
      b = y;
      rnd = 3'(rm);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
`ifdef FP_MULT_IN_REG_EN
      @(posedge clk);
      #1;
`endif
      check({tag, ".v"}, 32'(out_valid), 32'd1);
      check({tag, ".z"}, 32'(z), 32'(ez));
      check({tag, ".st"}, 32'(status), 32'(est));
   endtask

   initial begin
      logic [W-1:0] x, y;
      logic [W+7:0] m;
      int           rm;
      repeat (2) @(posedge clk);
      #1;
      check("rst.v", 32'(out_valid), 32'd0);
      check("rst.z", 32'(z), 32'd0);
      check("rst.st", 32'(status), 32'd0);
      reset = 1'b1;
      run("one", 16'h3C00, 16'h3C00, 0, 16'h3C00, 8'h00);
      run("ovf_rne", 16'h7BFF, 16'h4000, 0, 16'h7C00, 8'h32);
      run("ovf_rtz", 16'h7BFF, 16'h4000, 1, 16'h7BFF, 8'h30);
      run("ovf_rdn", 16'hFBFF, 16'h4000, 2, 16'hFC00, 8'h32);
      run("zero_inf", 16'h0000, 16'h7C00, 0, 16'h7E00, 8'h04);
      run("nan_in", 16'h7E01, 16'h3C00, 0, 16'h7E00, 8'h04);
      run("uflow_rne", 16'h0001, 16'h3800, 0, 16'h0000, 8'h29);
      run("uflow_rup", 16'h0001, 16'h3800, 3, 16'h0001, 8'h28);
      run("sub_exact", 16'h0001, 16'h3C00, 1, 16'h0001, 8'h08);
      run("rnd7", 16'hBC00, 16'h4000, 7, 16'hC000, 8'h00);
      a = 16'h4000;
      b = 16'h4000;
      @(posedge clk);
      #1;
      check("hold.v", 32'(out_valid), 32'd0);
      check("hold.z", 32'(z), 32'h0000C000);
      check("hold.st", 32'(status), 32'd0);
      a = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rstv.v", 32'(out_valid), 32'd0);
      check("rstv.z", 32'(z), 32'd0);
      check("rstv.st", 32'(status), 32'd0);
      reset = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         x  = rand_op();
         y  = rand_op();
         rm = $urandom_range(0, 7);
         m  = model(x, y, rm);
         run($sformatf("r%0d_%h_%h_%0d", i, x, y, rm), x, y, rm, m[W+7:8], m[7:0]);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
